btb_assoc: RTL and testbench
============================

Name: btb_assoc

Overview:
- Parametrised, set-associative branch target buffer for the fetch stage; successor to the current fixed 64x8 BTB.
- Lookup is registered: one cycle from the fetch PC to the predicted branch.
- Adds: update-in-place of existing entries (no duplicates), explicit entry removal, per-set rotating second-chance replacement, and a set-walking init/flush state machine.
- Sits between the PC generator (lookup), the direction predictor (taken input) and branch resolution (update port).

Parameters:
- NUM_ENTRIES, 64: total entries; must be a power of two.
- ASSOC, 8: ways per set; power of two, at least 2.
- PC_W, 31: halfword-granular PC width.
- OFFS_W, 3: fetch-block offset bits.
- Derived: LENGTH = NUM_ENTRIES/ASSOC; IDX_W = clog2(LENGTH); TAG_W = PC_W - OFFS_W - IDX_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- IN_pcValid  in  1  lookup request
- IN_pc  in  PC_W  fetch PC
- OUT_ready  out  1  high in IDLE; low while walking
- OUT_valid  out  1  registered copy of IN_pcValid AND OUT_ready
- OUT_branchFound  out  1  qualifying entry hit
- OUT_branchSrc  out  PC_W  branch source PC
- OUT_branchDst  out  PC_W  branch target PC
- OUT_branchIsJump  out  1  unconditional jump
- OUT_branchCompr  out  1  compressed instruction
- OUT_multipleBranches  out  1  more than one qualifying entry
- IN_BPT_branchTaken  in  1  predictor direction; aligned with OUT_valid
- IN_upd_valid  in  1  update request
- IN_upd_clear  in  1  1 = remove the entry matching IN_upd_src
- IN_upd_src  in  PC_W  branch source PC
- IN_upd_dst  in  PC_W  branch target PC
- IN_upd_isJump  in  1  jump flag to store
- IN_upd_compr  in  1  compressed flag to store
- IN_flush  in  1  invalidate all entries

Behaviour:
- Entry fields: valid, used, isJump, compr, tag[TAG_W], offs[OFFS_W], dst[PC_W].
- Per-set state: victim pointer vptr[clog2(ASSOC)].
- Storage: one read port (lookup), one write port per cycle. Update and replacement logic may read a second set combinationally.
- FSM states: INIT, IDLE.
  - rst → INIT, walk index 0, all outputs 0.
  - INIT: each cycle clears valid, used and vptr of set[idx]; idx++. After set LENGTH-1 is cleared → IDLE, so INIT lasts exactly LENGTH cycles.
  - IDLE: IN_flush → INIT at idx 0.
  - rst mid-walk restarts the walk from idx 0. IN_flush during INIT is ignored.
- Lookup (IDLE only), cycle N, indexed by IN_pc[OFFS_W+IDX_W-1:OFFS_W]:
  - A way qualifies if valid, tag equal, and offs >= IN_pc offset.
  - The qualifier with the lowest offs wins; OUT_multipleBranches = 1 if two or more qualify.
  - Outputs are registered and visible in cycle N+1.
  - With OUT_valid = 0, OUT_branchFound and OUT_multipleBranches are 0; Src/Dst hold their last value.
  - A request while OUT_ready = 0 gives OUT_valid = 0 next cycle.
- Used marking: in cycle N+1, if OUT_branchFound and (IN_BPT_branchTaken or OUT_branchIsJump), the hit way's used bit is set.
- Update (IDLE only; dropped when OUT_ready = 0):
  - Clear: the matching way (tag and offs equal) gets valid = 0; no match means no-op.
  - Insert, existing match: rewrite that way in place; used = 0.
  - Insert, no match, an invalid way exists: use the lowest-index invalid way.
  - Insert, set full: scan from vptr circularly for the first way with used = 0, clearing used on every skipped way. If every way is used, take the way at vptr and clear all used bits in the set.
  - vptr = victim + 1 (mod ASSOC). A newly written entry has used = 0.
- Write-port conflict: an update has priority over used marking in the same cycle, and the mark is dropped. IN_flush in the same cycle as an update: the flush wins and the update is dropped.

Optional Feature:
- Macro: BTB_PERF_EN.
- Defined: adds 32-bit outputs OUT_perfHits, OUT_perfLookups and OUT_perfEvictions.
  - Hits count valid lookups with OUT_branchFound; lookups count valid lookups; evictions count replacements of valid entries.
  - Counters wrap modulo 2^32, clear on rst, and are not cleared by IN_flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package btb_pkg holds:
  - the btb_entry_t struct;
  - the btb_update_t struct (valid, clear, src, dst, isJump, compr);
  - an FSM state enum (INIT, IDLE).
- Sub-module btb_victim_sel, combinational: inputs are the valid/used vectors and vptr; outputs are the victim way and the new used vector.

Test Plan:
- Reset walk: assert rst, then release → OUT_ready low for exactly 8 cycles (defaults), then high; lookup at 0x100 → found = 0.
- Insert then lookup: insert src 0x105, dst 0x2000; lookup pc 0x104 → next cycle found = 1, Dst 0x2000, Src 0x105. Lookup pc 0x106 → found = 0.
- Multiple branches: insert offs 6 and 2 in the same block; lookup offs 0 → Src offs 2, multipleBranches = 1.
- Update in place: re-insert src 0x105, dst 0x3000 → a single way is used in the set; lookup returns Dst 0x3000.
- Replacement: fill all 8 ways of a set, mark ways 0–2 used via taken hits, insert a 9th branch → way 3 is evicted, vptr = 4, and ways 0–2 have used cleared.
- Flush and conflict:
  - IN_flush in the same cycle as an update → update dropped; 8-cycle walk; prior entries miss.
  - Update in the same cycle as a taken hit → hit way's used bit stays 0.

Source files
------------

// File: rtl/btb_pkg.sv
// btb_pkg: shared types and default widths for the set-associative branch target buffer
package btb_pkg;
  localparam int BTB_PC_W = 31;
  localparam int BTB_OFFS_W = 3;
  // Widest tag any legal geometry can need (at least one index bit); narrower tags are zero-extended.
  localparam int BTB_TAG_MAX_W = BTB_PC_W - BTB_OFFS_W - 1;
  typedef enum logic {INIT, IDLE} btb_state_t;
  typedef struct packed {
    logic valid;
    logic used;
    logic is_jump;
    logic compr;
    logic [BTB_TAG_MAX_W-1:0] tag;
    logic [BTB_OFFS_W-1:0] offs;
    logic [BTB_PC_W-1:0] dst;
  } btb_entry_t;
  typedef struct packed {
    logic valid;
    logic clear;
    logic [BTB_PC_W-1:0] src;
    logic [BTB_PC_W-1:0] dst;
    logic is_jump;
    logic compr;
  } btb_update_t;
endpackage

// File: rtl/btb_assoc_if.sv
// btb_assoc_if: lookup, prediction, update and flush signals of the branch target buffer
interface btb_assoc_if import btb_pkg::*; #(parameter int PC_W = BTB_PC_W);
  logic IN_pcValid;
  logic [PC_W-1:0] IN_pc;
  logic OUT_ready;
  logic OUT_valid;
  logic OUT_branchFound;
  logic [PC_W-1:0] OUT_branchSrc;
  logic [PC_W-1:0] OUT_branchDst;
  logic OUT_branchIsJump;
  logic OUT_branchCompr;
  logic OUT_multipleBranches;
  logic IN_BPT_branchTaken;
  logic IN_upd_valid;
  logic IN_upd_clear;
  logic [PC_W-1:0] IN_upd_src;
  logic [PC_W-1:0] IN_upd_dst;
  logic IN_upd_isJump;
  logic IN_upd_compr;
  logic IN_flush;
  modport slave (
    input IN_pcValid, IN_pc, IN_BPT_branchTaken, IN_upd_valid, IN_upd_clear, IN_upd_src,
          IN_upd_dst, IN_upd_isJump, IN_upd_compr, IN_flush,
    output OUT_ready, OUT_valid, OUT_branchFound, OUT_branchSrc, OUT_branchDst,
           OUT_branchIsJump, OUT_branchCompr, OUT_multipleBranches
  );
  modport master (
    output IN_pcValid, IN_pc, IN_BPT_branchTaken, IN_upd_valid, IN_upd_clear, IN_upd_src,
           IN_upd_dst, IN_upd_isJump, IN_upd_compr, IN_flush,
    input OUT_ready, OUT_valid, OUT_branchFound, OUT_branchSrc, OUT_branchDst,
          OUT_branchIsJump, OUT_branchCompr, OUT_multipleBranches
  );
endinterface

// File: rtl/btb_victim_sel.sv
// btb_victim_sel: picks the way to overwrite; lowest invalid way, else second-chance scan from vptr
module btb_victim_sel #(
  parameter int ASSOC = 8,
  localparam int WAY_W = $clog2(ASSOC)
) (
  input  logic [ASSOC-1:0] valid,
  input  logic [ASSOC-1:0] used,
  input  logic [WAY_W-1:0] vptr,
  output logic [WAY_W-1:0] victim,
  output logic [ASSOC-1:0] used_nx
);
  logic [WAY_W-1:0] w;
  logic hit;
  always_comb begin
    victim = vptr;
    used_nx = used;
    hit = 1'b0;
    w = '0;
    for (int k = 0; k < ASSOC; k++) begin
      w = vptr + WAY_W'(k);
      if (!hit) begin
        if (used[w]) used_nx[w] = 1'b0;
        else begin
          hit = 1'b1;
          victim = w;
        end
      end
    end
    // When every way was skipped, all used bits are already cleared and victim stays at vptr.
    if (!(&valid)) begin
      used_nx = used;
      for (int k = ASSOC - 1; k >= 0; k--)
        if (!valid[k]) victim = WAY_W'(k);
    end
  end
endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative BTB with registered lookup, in-place update and init/flush walk.
// Define BTB_PERF_EN to add hit/lookup/eviction counters.
module btb_assoc import btb_pkg::*; #(
  parameter int NUM_ENTRIES = 64,
  parameter int ASSOC = 8,
  parameter int PC_W = BTB_PC_W,
  parameter int OFFS_W = BTB_OFFS_W
) (
  input logic clk,
  input logic rst,
  btb_assoc_if.slave bus
`ifdef BTB_PERF_EN
  ,
  output logic [31:0] OUT_perfHits,
  output logic [31:0] OUT_perfLookups,
  output logic [31:0] OUT_perfEvictions
`endif
);
  localparam int LENGTH = NUM_ENTRIES / ASSOC;
  localparam int IDX_W = $clog2(LENGTH);
  localparam int WAY_W = $clog2(ASSOC);
  localparam int TAG_W = PC_W - OFFS_W - IDX_W;

  function automatic logic [BTB_TAG_MAX_W-1:0] tag_of(input logic [PC_W-1:0] pc);
    return BTB_TAG_MAX_W'(pc[PC_W-1:OFFS_W+IDX_W]);
  endfunction

  btb_entry_t mem [LENGTH][ASSOC];
  logic [WAY_W-1:0] vptr [LENGTH];
  btb_state_t state, state_nx;
  logic [IDX_W-1:0] walk_idx;
  logic ready;

  assign ready = state == IDLE;

  always_comb state_nx = (state == INIT) ? ((&walk_idx) ? IDLE : INIT) : (bus.IN_flush ? INIT : IDLE);

  always_ff @(posedge clk)
    if (rst) begin
      state <= INIT;
      walk_idx <= '0;
    end else begin
      state <= state_nx;
      walk_idx <= (state == INIT) ? walk_idx + 1'b1 : '0;
    end

  logic [IDX_W-1:0] lk_idx;
  logic [OFFS_W-1:0] lk_offs;
  logic [BTB_TAG_MAX_W-1:0] lk_tag;
  logic [ASSOC-1:0] lk_qual;
  logic [WAY_W-1:0] lk_way;
  logic lk_hit, lk_multi, lk_go;

  assign lk_idx = bus.IN_pc[OFFS_W+IDX_W-1:OFFS_W];
  assign lk_offs = bus.IN_pc[OFFS_W-1:0];
  assign lk_tag = tag_of(bus.IN_pc);
  assign lk_go = bus.IN_pcValid && ready;

  // Among qualifying ways the lowest offset is the first branch the fetch block reaches.
  always_comb begin
    lk_qual = '0;
    lk_way = '0;
    lk_hit = 1'b0;
    lk_multi = 1'b0;
    for (int w = 0; w < ASSOC; w++)
      lk_qual[w] = mem[lk_idx][w].valid && mem[lk_idx][w].tag == lk_tag && mem[lk_idx][w].offs >= lk_offs;
    for (int w = 0; w < ASSOC; w++)
      if (lk_qual[w]) begin
        lk_multi = lk_multi | lk_hit;
        if (!lk_hit || mem[lk_idx][w].offs < mem[lk_idx][lk_way].offs) lk_way = WAY_W'(w);
        lk_hit = 1'b1;
      end
  end

  logic out_valid, out_found, out_multi, out_jump, out_compr;
  logic [PC_W-1:0] out_src, out_dst;
  logic [WAY_W-1:0] hit_way;
  logic [IDX_W-1:0] hit_idx;

  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_found <= 1'b0;
      out_multi <= 1'b0;
      out_jump <= 1'b0;
      out_compr <= 1'b0;
      out_src <= '0;
      out_dst <= '0;
      hit_way <= '0;
      hit_idx <= '0;
    end else begin
      out_valid <= lk_go;
      out_found <= lk_go && lk_hit;
      out_multi <= lk_go && lk_multi;
      if (lk_go && lk_hit) begin
        out_src <= {mem[lk_idx][lk_way].tag[TAG_W-1:0], lk_idx, mem[lk_idx][lk_way].offs};
        out_dst <= mem[lk_idx][lk_way].dst;
        out_jump <= mem[lk_idx][lk_way].is_jump;
        out_compr <= mem[lk_idx][lk_way].compr;
        hit_way <= lk_way;
        hit_idx <= lk_idx;
      end
    end

  assign bus.OUT_ready = ready;
  assign bus.OUT_valid = out_valid;
  assign bus.OUT_branchFound = out_found;
  assign bus.OUT_multipleBranches = out_multi;
  assign bus.OUT_branchSrc = out_src;
  assign bus.OUT_branchDst = out_dst;
  assign bus.OUT_branchIsJump = out_jump;
  assign bus.OUT_branchCompr = out_compr;

  btb_update_t upd;
  logic [IDX_W-1:0] u_idx;
  logic [OFFS_W-1:0] u_offs;
  logic [BTB_TAG_MAX_W-1:0] u_tag;
  logic [ASSOC-1:0] u_match, u_valid_v, u_used_v, sel_used;
  logic [WAY_W-1:0] u_mway, sel_way, ins_way;

  assign upd = '{valid: bus.IN_upd_valid, clear: bus.IN_upd_clear, src: bus.IN_upd_src,
                 dst: bus.IN_upd_dst, is_jump: bus.IN_upd_isJump, compr: bus.IN_upd_compr};
  assign u_idx = upd.src[OFFS_W+IDX_W-1:OFFS_W];
  assign u_offs = upd.src[OFFS_W-1:0];
  assign u_tag = tag_of(upd.src);

  always_comb begin
    u_match = '0;
    u_valid_v = '0;
    u_used_v = '0;
    u_mway = '0;
    for (int w = 0; w < ASSOC; w++) begin
      u_match[w] = mem[u_idx][w].valid && mem[u_idx][w].tag == u_tag && mem[u_idx][w].offs == u_offs;
      u_valid_v[w] = mem[u_idx][w].valid;
      u_used_v[w] = mem[u_idx][w].used;
    end
    for (int w = ASSOC - 1; w >= 0; w--)
      if (u_match[w]) u_mway = WAY_W'(w);
  end

  btb_victim_sel #(.ASSOC(ASSOC)) u_sel (
    .valid(u_valid_v),
    .used(u_used_v),
    .vptr(vptr[u_idx]),
    .victim(sel_way),
    .used_nx(sel_used)
  );

  assign ins_way = (|u_match) ? u_mway : sel_way;

  // Single write port: walk, then update, then used marking; a flush suppresses both of the latter.
  logic upd_go, mark_go, wr_en, evict;
  logic [IDX_W-1:0] wr_idx;
  logic [WAY_W-1:0] wr_vptr;
  btb_entry_t wr_row [ASSOC];

  assign upd_go = ready && upd.valid && !bus.IN_flush;
  assign mark_go = ready && !bus.IN_flush && !upd_go && out_found && (bus.IN_BPT_branchTaken || out_jump);
  assign wr_en = state == INIT || upd_go || mark_go;
  assign wr_idx = (state == INIT) ? walk_idx : upd_go ? u_idx : hit_idx;

  always_comb begin
    wr_vptr = vptr[wr_idx];
    evict = 1'b0;
    for (int w = 0; w < ASSOC; w++) wr_row[w] = (state == INIT) ? '0 : mem[wr_idx][w];
    if (state == INIT) wr_vptr = '0;
    else if (upd_go && upd.clear) begin
      if (|u_match) wr_row[u_mway].valid = 1'b0;
    end else if (upd_go) begin
      if (!(|u_match))
        for (int w = 0; w < ASSOC; w++) wr_row[w].used = sel_used[w];
      wr_row[ins_way] = '{valid: 1'b1, used: 1'b0, is_jump: upd.is_jump, compr: upd.compr,
                          tag: u_tag, offs: u_offs, dst: upd.dst};
      if (!(|u_match) && (&u_valid_v)) begin
        wr_vptr = sel_way + 1'b1;
        evict = 1'b1;
      end
    end else if (mark_go) wr_row[hit_way].used = 1'b1;
  end

  always_ff @(posedge clk)
    if (!rst && wr_en) begin
      for (int w = 0; w < ASSOC; w++) mem[wr_idx][w] <= wr_row[w];
      vptr[wr_idx] <= wr_vptr;
    end

`ifdef BTB_PERF_EN
  always_ff @(posedge clk)
    if (rst) begin
      OUT_perfHits <= '0;
      OUT_perfLookups <= '0;
      OUT_perfEvictions <= '0;
    end else begin
      OUT_perfHits <= OUT_perfHits + 32'(out_valid && out_found);
      OUT_perfLookups <= OUT_perfLookups + 32'(out_valid);
      OUT_perfEvictions <= OUT_perfEvictions + 32'(evict);
    end
`endif
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed bench for btb_assoc; lookup results are checked through an expectation queue
module tb_btb_assoc;
  typedef struct packed {
    logic found;
    logic multi;
    logic [30:0] src;
    logic [30:0] dst;
  } exp_t;

  logic clk, rst;
  int checks = 0, errors = 0;
  exp_t sb[$];

  btb_assoc_if bus();
  btb_assoc dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [30:0] src, input logic [30:0] dst, input logic clr);
    bus.IN_upd_valid = 1'b1;
    bus.IN_upd_clear = clr;
    bus.IN_upd_src = src;
    bus.IN_upd_dst = dst;
    step();
    bus.IN_upd_valid = 1'b0;
    bus.IN_upd_clear = 1'b0;
  endtask

  task automatic look(input logic [30:0] pc, input logic f, input logic [30:0] s, input logic [30:0] d,
                      input logic m, input logic taken);
    bus.IN_pcValid = 1'b1;
    bus.IN_pc = pc;
    sb.push_back('{found: f, multi: m, src: s, dst: d});
    step();
    bus.IN_pcValid = 1'b0;
    bus.IN_BPT_branchTaken = taken;
    step();
    bus.IN_BPT_branchTaken = 1'b0;
  endtask

  always @(negedge clk)
    if (bus.OUT_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
      else begin
        automatic exp_t e = sb.pop_front();
        chk("found", 64'(bus.OUT_branchFound), 64'(e.found));
        chk("multi", 64'(bus.OUT_multipleBranches), 64'(e.multi));
        if (e.found) begin
          chk("src", 64'(bus.OUT_branchSrc), 64'(e.src));
          chk("dst", 64'(bus.OUT_branchDst), 64'(e.dst));
        end
      end
    end

  function automatic logic [30:0] rpc(input int t);
    return 31'((t << 6) | 'h10);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, nvalid;
    rst = 1'b1;
    bus.IN_pcValid = 1'b0;
    bus.IN_pc = '0;
    bus.IN_BPT_branchTaken = 1'b0;
    bus.IN_upd_valid = 1'b0;
    bus.IN_upd_clear = 1'b0;
    bus.IN_upd_src = '0;
    bus.IN_upd_dst = '0;
    bus.IN_upd_isJump = 1'b0;
    bus.IN_upd_compr = 1'b0;
    bus.IN_flush = 1'b0;
    repeat (3) step();
    chk("rst_valid", 64'(bus.OUT_valid), 64'd0);
    chk("rst_found", 64'(bus.OUT_branchFound), 64'd0);
    chk("rst_src", 64'(bus.OUT_branchSrc), 64'd0);
    chk("rst_ready", 64'(bus.OUT_ready), 64'd0);
    rst = 1'b0;
    cnt = 0;
    while (bus.OUT_ready !== 1'b1 && cnt < 100) begin
      cnt++;
      step();
    end
    chk("init_walk_len", 64'(cnt), 64'd8);
    look(31'h100, 1'b0, '0, '0, 1'b0, 1'b0);

    upd(31'h105, 31'h2000, 1'b0);
    look(31'h104, 1'b1, 31'h105, 31'h2000, 1'b0, 1'b0);
    look(31'h105, 1'b1, 31'h105, 31'h2000, 1'b0, 1'b0);
    look(31'h106, 1'b0, '0, '0, 1'b0, 1'b0);

    upd(31'h20E, 31'h2E0, 1'b0);
    upd(31'h20A, 31'h2A0, 1'b0);
    look(31'h208, 1'b1, 31'h20A, 31'h2A0, 1'b1, 1'b0);
    look(31'h20B, 1'b1, 31'h20E, 31'h2E0, 1'b0, 1'b0);
    look(31'h20F, 1'b0, '0, '0, 1'b0, 1'b0);
    upd(31'h20A, '0, 1'b1);
    look(31'h208, 1'b1, 31'h20E, 31'h2E0, 1'b0, 1'b0);

    upd(31'h105, 31'h3000, 1'b0);
    nvalid = 0;
    for (int w = 0; w < 8; w++) nvalid += int'(dut.mem[0][w].valid);
    chk("in_place_ways", 64'(nvalid), 64'd1);
    look(31'h104, 1'b1, 31'h105, 31'h3000, 1'b0, 1'b0);

    for (int t = 1; t <= 8; t++) upd(rpc(t), 31'(32'h1000 + t), 1'b0);
    for (int t = 1; t <= 3; t++) look(rpc(t), 1'b1, rpc(t), 31'(32'h1000 + t), 1'b0, 1'b1);
    chk("marked_w2", 64'(dut.mem[2][2].used), 64'd1);
    upd(rpc(9), 31'h1009, 1'b0);
    chk("repl_vptr", 64'(dut.vptr[2]), 64'd4);
    chk("repl_tag_w3", 64'(dut.mem[2][3].tag), 64'd9);
    for (int w = 0; w < 3; w++) chk("repl_used_clr", 64'(dut.mem[2][w].used), 64'd0);
    look(rpc(4), 1'b0, '0, '0, 1'b0, 1'b0);
    look(rpc(9), 1'b1, rpc(9), 31'h1009, 1'b0, 1'b0);
    look(rpc(5), 1'b1, rpc(5), 31'h1005, 1'b0, 1'b0);

    bus.IN_flush = 1'b1;
    upd(31'h300, 31'h4000, 1'b0);
    bus.IN_flush = 1'b0;
    chk("flush_ready", 64'(bus.OUT_ready), 64'd0);
    cnt = 1;
    bus.IN_pcValid = 1'b1;
    bus.IN_pc = 31'h104;
    step();
    bus.IN_pcValid = 1'b0;
    chk("busy_lookup_valid", 64'(bus.OUT_valid), 64'd0);
    while (bus.OUT_ready !== 1'b1 && cnt < 100) begin
      cnt++;
      step();
    end
    chk("flush_walk_len", 64'(cnt), 64'd8);
    look(31'h104, 1'b0, '0, '0, 1'b0, 1'b0);
    look(31'h300, 1'b0, '0, '0, 1'b0, 1'b0);
    look(rpc(9), 1'b0, '0, '0, 1'b0, 1'b0);

    upd(31'h105, 31'h2000, 1'b0);
    bus.IN_pcValid = 1'b1;
    bus.IN_pc = 31'h104;
    sb.push_back('{found: 1'b1, multi: 1'b0, src: 31'h105, dst: 31'h2000});
    step();
    bus.IN_pcValid = 1'b0;
    bus.IN_BPT_branchTaken = 1'b1;
    upd(31'h0D, 31'h10, 1'b0);
    bus.IN_BPT_branchTaken = 1'b0;
    chk("conflict_used", 64'(dut.mem[0][0].used), 64'd0);
    chk("conflict_upd_done", 64'(dut.mem[1][0].valid), 64'd1);
    look(31'h104, 1'b1, 31'h105, 31'h2000, 1'b0, 1'b1);
    chk("taken_used", 64'(dut.mem[0][0].used), 64'd1);
    look(31'h08, 1'b1, 31'h0D, 31'h10, 1'b0, 1'b0);

    repeat (3) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
